// File: rtl/cm_region_cfg.sv
// Colour-region configuration decoder: turns byte commands from a FWFT FIFO into colour-write handshakes.
// Define CM_TIMEOUT_EN to build the inter-byte timeout in DATA (error code 11).
//
// state | meaning
// IDLE  | waiting for and consuming a header byte
// DATA  | shifting in the colour data bytes, MSB first
// ISSUE | presenting one colour write until c_ready
// CLEAR | writing zero to every region in turn
// ERR   | one-cycle error report, then back to IDLE
module cm_region_cfg #(
  parameter int  UART_DATA_WIDTH = 8,
  parameter int  NUM_REGIONS     = 4,
  parameter int  COLOR_WIDTH     = 12,
  parameter int  TIMEOUT_CYCLES  = 1000,
  localparam int c_addr_WIDTH    = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       Empty,
  input  logic [UART_DATA_WIDTH-1:0] RXD_Data,
  output logic                       Rd_En,
  output logic [c_addr_WIDTH-1:0]    c_addr,
  output logic [COLOR_WIDTH-1:0]     c_data,
  output logic                       c_valid,
  input  logic                       c_ready,
  output logic [1:0]                 Config_Status,
  output logic [1:0]                 Config_Error,
  output logic                       Error_Valid,
  output logic [c_addr_WIDTH-1:0]    Config_Notification,
  output logic                       Config_Notification_Valid
);

  localparam int NB = (COLOR_WIDTH + 7) / 8;
  localparam int SW = NB * 8;
  localparam logic [c_addr_WIDTH-1:0] c_last_addr = c_addr_WIDTH'(NUM_REGIONS - 1);

  if (NUM_REGIONS < 1 || NUM_REGIONS > 64 || COLOR_WIDTH < 1 || COLOR_WIDTH > 32 ||
      TIMEOUT_CYCLES < 1 || UART_DATA_WIDTH < 8) begin : g_bad_params
    $error("cm_region_cfg: parameter out of range");
  end

  typedef enum logic [2:0] {S_IDLE, S_DATA, S_ISSUE, S_CLEAR, S_ERR} state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [5:0]              r_region;
  logic [SW-1:0]           r_shift;
  logic [SW-1:0]           w_shift_next;
  logic [2:0]              r_cnt;
  logic [c_addr_WIDTH-1:0] r_addr;
  logic [COLOR_WIDTH-1:0]  r_data;
  logic [1:0]              r_err;
  logic [1:0]              w_err_next;
  logic [c_addr_WIDTH-1:0] r_notif;
  logic                    r_notif_valid;
  logic                    w_last_byte;
  logic                    w_region_ok;
`ifdef CM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]           r_tmo;
`endif

  assign w_shift_next = SW'({r_shift, RXD_Data[7:0]});
  assign w_last_byte  = (r_cnt == 3'd0);
  assign w_region_ok  = ({1'b0, r_region} < 7'(NUM_REGIONS));

  // Reset gates Rd_En so no byte is lost while the FSM is held.
  assign Rd_En   = !rst && !Empty && (r_state == S_IDLE || r_state == S_DATA);
  assign c_valid = (r_state == S_ISSUE) || (r_state == S_CLEAR);
  assign Error_Valid               = (r_state == S_ERR);
  assign c_addr                    = r_addr;
  assign c_data                    = r_data;
  assign Config_Error              = r_err;
  assign Config_Notification       = r_notif;
  assign Config_Notification_Valid = r_notif_valid;

  always_comb begin
    Config_Status = 2'b00;
    case (r_state)
      S_DATA:  Config_Status = 2'b01;
      S_ISSUE: Config_Status = 2'b10;
      S_CLEAR: Config_Status = 2'b11;
      default: Config_Status = 2'b00;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_err_next   = r_err;
    case (r_state)
      S_IDLE: begin
        if (!Empty) begin
          case (RXD_Data[7:6])
            2'b00:   w_state_next = S_DATA;
            2'b01:   w_state_next = S_CLEAR;
            default: begin
              w_state_next = S_ERR;
              w_err_next   = 2'b10;
            end
          endcase
        end
      end
      S_DATA: begin
        if (!Empty) begin
          if (w_last_byte) begin
            if (w_region_ok) begin
              w_state_next = S_ISSUE;
            end else begin
              w_state_next = S_ERR;
              w_err_next   = 2'b01;
            end
          end
        end
`ifdef CM_TIMEOUT_EN
        else if (r_tmo == '0) begin
          w_state_next = S_ERR;
          w_err_next   = 2'b11;
        end
`endif
      end
      S_ISSUE: if (c_ready) w_state_next = S_IDLE;
      S_CLEAR: if (c_ready && r_addr == c_last_addr) w_state_next = S_IDLE;
      S_ERR:   w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_region      <= '0;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_addr        <= '0;
      r_data        <= '0;
      r_err         <= '0;
      r_notif       <= '0;
      r_notif_valid <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_err         <= w_err_next;
      r_notif_valid <= c_valid && c_ready;
      if (c_valid && c_ready) r_notif <= r_addr;
      case (r_state)
        S_IDLE: begin
          if (!Empty) begin
            r_region <= RXD_Data[5:0];
            r_cnt    <= 3'(NB - 1);
            r_shift  <= '0;
            if (RXD_Data[7:6] == 2'b01) begin
              r_addr <= '0;
              r_data <= '0;
            end
          end
        end
        S_DATA: begin
          if (!Empty) begin
            r_shift <= w_shift_next;
            r_cnt   <= r_cnt - 3'd1;
            if (w_last_byte && w_region_ok) begin
              r_addr <= r_region[c_addr_WIDTH-1:0];
              r_data <= w_shift_next[COLOR_WIDTH-1:0];
            end
          end
        end
        S_CLEAR: if (c_ready) r_addr <= r_addr + c_addr_WIDTH'(1);
        default: ;
      endcase
    end
  end

`ifdef CM_TIMEOUT_EN
  // Down-counter of consecutive empty cycles in DATA; reloaded by every byte consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmo <= '0;
    end else if (Rd_En) begin
      r_tmo <= TW'(TIMEOUT_CYCLES - 1);
    end else if (r_state == S_DATA && r_tmo != '0) begin
      r_tmo <= r_tmo - TW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_cm_region_cfg.sv
// Self-checking bench for cm_region_cfg: table vectors, directed corner sequences, random commands vs a byte-stream model.
`timescale 1ns/1ps
module tb_cm_region_cfg;
  localparam int NUM_REGIONS = 4;
  localparam int COLOR_WIDTH = 12;
  localparam int NB          = 2;
  localparam int AW          = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          Empty;
  logic [7:0]    RXD_Data;
  logic          Rd_En;
  logic [AW-1:0] c_addr;
  logic [11:0]   c_data;
  logic          c_valid;
  logic          c_ready;
  logic [1:0]    Config_Status;
  logic [1:0]    Config_Error;
  logic          Error_Valid;
  logic [AW-1:0] Config_Notification;
  logic          Config_Notification_Valid;

  always #5 clk = ~clk;

  cm_region_cfg #(
    .UART_DATA_WIDTH(8), .NUM_REGIONS(NUM_REGIONS), .COLOR_WIDTH(COLOR_WIDTH), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .rst(rst), .Empty(Empty), .RXD_Data(RXD_Data), .Rd_En(Rd_En),
    .c_addr(c_addr), .c_data(c_data), .c_valid(c_valid), .c_ready(c_ready),
    .Config_Status(Config_Status), .Config_Error(Config_Error), .Error_Valid(Error_Valid),
    .Config_Notification(Config_Notification),
    .Config_Notification_Valid(Config_Notification_Valid)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] fifo[$];
  int got_addr[$], got_data[$], got_err[$], got_notif[$];
  int exp_addr[$], exp_data[$], exp_err[$];
  int pops;
  bit s_pop;
  int ready_mode;   // 0 held low, 1 held high, 2 random
  bit rand_gaps;
  int gap_left;
  bit gap_cool;

  typedef struct {
    int         nbytes;
    logic [7:0] b0, b1, b2;
    int         kind;     // 0 write, 1 clear, 2 error
    int         addr;
    int         data;
    int         err;
  } vec_t;
  vec_t vt[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sample();
    s_pop = Rd_En;
    if (Rd_En) begin
      check("rden_not_empty", Empty, 0);
      check("rden_state", Config_Status[1], 0);
    end
    check("rden_with_valid", Rd_En & c_valid, 0);
    if (c_valid && got_addr.size() < exp_addr.size()) begin
      check("valid_addr", c_addr, exp_addr[got_addr.size()]);
      check("valid_data", c_data, exp_data[got_addr.size()]);
    end
    if (!rst) begin
      if (c_valid && c_ready) begin
        got_addr.push_back(int'(c_addr));
        got_data.push_back(int'(c_data));
      end
      if (Error_Valid) got_err.push_back(int'(Config_Error));
      if (Config_Notification_Valid) got_notif.push_back(int'(Config_Notification));
      if (Rd_En) pops++;
    end
  endtask

  task automatic drive();
    bit gap;
    gap = 1'b0;
    if (s_pop && fifo.size() > 0) void'(fifo.pop_front());
    if (gap_left > 0) begin
      gap = 1'b1;
      gap_left--;
      if (gap_left == 0) gap_cool = 1'b1;
    end else if (gap_cool) begin
      gap_cool = 1'b0;
    end else if (rand_gaps && $urandom_range(0, 5) == 0) begin
      gap = 1'b1;
      gap_left = int'($urandom_range(0, 2));
      if (gap_left == 0) gap_cool = 1'b1;
    end
    Empty    = gap || (fifo.size() == 0);
    RXD_Data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    case (ready_mode)
      0:       c_ready = 1'b0;
      1:       c_ready = 1'b1;
      default: c_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic clear_logs();
    got_addr.delete(); got_data.delete(); got_err.delete(); got_notif.delete();
    exp_addr.delete(); exp_data.delete(); exp_err.delete();
    pops = 0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int quiet;
    int n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      tick();
      n++;
      if (fifo.size() == 0 && Config_Status == 2'b00 && !Config_Notification_Valid && !Error_Valid)
        quiet++;
      else
        quiet = 0;
    end
    check({name, "_drain_timeout"}, quiet >= 3, 1);
  endtask

  task automatic compare_logs(input string name);
    check({name, "_n_writes"}, got_addr.size(), exp_addr.size());
    for (int i = 0; i < got_addr.size() && i < exp_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", name, i), got_addr[i], exp_addr[i]);
      check($sformatf("%s_data%0d", name, i), got_data[i], exp_data[i]);
    end
    check({name, "_n_errors"}, got_err.size(), exp_err.size());
    for (int i = 0; i < got_err.size() && i < exp_err.size(); i++)
      check($sformatf("%s_err%0d", name, i), got_err[i], exp_err[i]);
    check({name, "_n_notif"}, got_notif.size(), exp_addr.size());
    for (int i = 0; i < got_notif.size() && i < exp_addr.size(); i++)
      check($sformatf("%s_notif%0d", name, i), got_notif[i], exp_addr[i]);
  endtask

  // Expected events of a complete byte stream, from the command rules alone.
  task automatic model(input logic [7:0] s[$]);
    int i;
    int op;
    int region;
    longint v;
    i = 0;
    while (i < s.size()) begin
      op     = int'(s[i]) / 64;
      region = int'(s[i]) % 64;
      i++;
      if (op == 0) begin
        v = 0;
        for (int k = 0; k < NB; k++) begin
          v = v * 256 + longint'(s[i]);
          i++;
        end
        if (region < NUM_REGIONS) begin
          exp_addr.push_back(region);
          exp_data.push_back(int'(v % (longint'(1) << COLOR_WIDTH)));
        end else begin
          exp_err.push_back(1);
        end
      end else if (op == 1) begin
        for (int a = 0; a < NUM_REGIONS; a++) begin
          exp_addr.push_back(a);
          exp_data.push_back(0);
        end
      end else begin
        exp_err.push_back(2);
      end
    end
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n;
    n = 0;
    while (!c_valid && n < budget) begin
      tick();
      n++;
    end
    check({name, "_valid_seen"}, c_valid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] cmd[$];
    rst = 1'b1; ready_mode = 1; rand_gaps = 1'b0; gap_left = 0; gap_cool = 1'b0; s_pop = 1'b0;
    pops = 0;
    drive();
    repeat (3) tick();
    check("rst_rden", Rd_En, 0);
    check("rst_valid", c_valid, 0);
    check("rst_err_valid", Error_Valid, 0);
    check("rst_notif_valid", Config_Notification_Valid, 0);
    check("rst_addr", c_addr, 0);
    check("rst_data", c_data, 0);
    check("rst_err", Config_Error, 0);
    check("rst_notif", Config_Notification, 0);
    check("rst_status", Config_Status, 0);
    rst = 1'b0;
    tick();
    check("idle_valid", c_valid, 0);
    check("idle_status", Config_Status, 0);

    vt[0] = '{3, 8'h02, 8'h05, 8'hA5, 0, 2, 'h5A5, 0};
    vt[1] = '{3, 8'h07, 8'h00, 8'h00, 2, 0, 0, 1};
    vt[2] = '{1, 8'h80, 8'h00, 8'h00, 2, 0, 0, 2};
    vt[3] = '{1, 8'h40, 8'h00, 8'h00, 1, 0, 0, 0};
    vt[4] = '{3, 8'h03, 8'hFF, 8'hFF, 0, 3, 'hFFF, 0};
    vt[5] = '{3, 8'h00, 8'h12, 8'h34, 0, 0, 'h234, 0};
    vt[6] = '{1, 8'hC5, 8'h00, 8'h00, 2, 0, 0, 2};
    vt[7] = '{3, 8'h04, 8'hAB, 8'hCD, 2, 0, 0, 1};
    vt[8] = '{3, 8'h01, 8'h80, 8'h01, 0, 1, 'h001, 0};
    for (int i = 0; i < 9; i++) begin
      clear_logs();
      fifo.push_back(vt[i].b0);
      if (vt[i].nbytes > 1) begin
        fifo.push_back(vt[i].b1);
        fifo.push_back(vt[i].b2);
      end
      if (vt[i].kind == 0) begin
        exp_addr.push_back(vt[i].addr);
        exp_data.push_back(vt[i].data);
      end else if (vt[i].kind == 1) begin
        for (int a = 0; a < NUM_REGIONS; a++) begin
          exp_addr.push_back(a);
          exp_data.push_back(0);
        end
      end else begin
        exp_err.push_back(vt[i].err);
      end
      drive();
      wait_idle($sformatf("vec%0d", i), 100);
      compare_logs($sformatf("vec%0d", i));
      check($sformatf("vec%0d_pops", i), pops, vt[i].nbytes);
      if (vt[i].kind == 2) check($sformatf("vec%0d_err_held", i), Config_Error, vt[i].err);
    end

    // Backpressure: the trailing header must wait in the FIFO until the write completes.
    clear_logs();
    ready_mode = 0;
    fifo.push_back(8'h02); fifo.push_back(8'h05); fifo.push_back(8'hA5); fifo.push_back(8'h01);
    exp_addr.push_back(2); exp_data.push_back('h5A5);
    exp_addr.push_back(1); exp_data.push_back('h345);
    drive();
    wait_valid("bp", 20);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_valid", c_valid, 1);
      check("bp_addr", c_addr, 2);
      check("bp_data", c_data, 'h5A5);
      check("bp_rden", Rd_En, 0);
      check("bp_fifo_level", fifo.size(), 1);
      check("bp_status", Config_Status, 2'b10);
    end
    ready_mode = 1;
    for (int i = 0; i < 10 && fifo.size() != 0; i++) tick();
    check("bp_header_popped", fifo.size(), 0);
    check("bp_writes_before_pop", got_addr.size(), 1);
    fifo.push_back(8'h23); fifo.push_back(8'h45);
    wait_idle("bp", 100);
    compare_logs("bp");
    check("bp_pops", pops, 6);

    // Inter-byte timeout / indefinite wait in DATA.
    clear_logs();
    fifo.push_back(8'h01); fifo.push_back(8'h0F);
    drive();
    for (int i = 0; i < 10 && fifo.size() != 0; i++) tick();
    check("tmo_bytes_popped", fifo.size(), 0);
`ifdef CM_TIMEOUT_EN
    repeat (20) tick();
    check("tmo_not_early", got_err.size(), 0);
    tick();
    check("tmo_fired", got_err.size(), 1);
    exp_err.push_back(3);
    wait_idle("tmo", 50);
    compare_logs("tmo");
    check("tmo_err_held", Config_Error, 2'b11);
`else
    repeat (100) tick();
    check("tmo_no_error", got_err.size(), 0);
    check("tmo_still_data", Config_Status, 2'b01);
    fifo.push_back(8'h3C);
    exp_addr.push_back(1); exp_data.push_back('hF3C);
    wait_idle("tmo", 50);
    compare_logs("tmo");
`endif

    // Reset while a write is stalled in ISSUE.
    clear_logs();
    ready_mode = 0;
    fifo.push_back(8'h02); fifo.push_back(8'h05); fifo.push_back(8'hA5);
    exp_addr.push_back(2); exp_data.push_back('h5A5);
    drive();
    wait_valid("rst_issue", 20);
    rst = 1'b1;
    tick();
    check("rst_issue_valid", c_valid, 0);
    check("rst_issue_status", Config_Status, 0);
    check("rst_issue_addr", c_addr, 0);
    check("rst_issue_data", c_data, 0);
    check("rst_issue_notif_valid", Config_Notification_Valid, 0);
    rst = 1'b0;
    ready_mode = 1;
    repeat (5) tick();
    check("rst_issue_no_write", got_addr.size(), 0);
    check("rst_issue_no_notif", got_notif.size(), 0);
    check("rst_issue_still_idle", c_valid, 0);

    // Random command streams against the model.
    for (int r = 0; r < 3; r++) begin
      clear_logs();
      cmd.delete();
      ready_mode = 2;
      rand_gaps = 1'b1;
      for (int c = 0; c < 40; c++) begin
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 7) begin
          cmd.push_back(8'($urandom_range(0, 7)));
          for (int k = 0; k < NB; k++) cmd.push_back(8'($urandom_range(0, 255)));
        end else if (sel == 7) begin
          cmd.push_back(8'h40 | 8'($urandom_range(0, 63)));
        end else begin
          cmd.push_back(8'($urandom_range(128, 255)));
        end
      end
      model(cmd);
      foreach (cmd[i]) fifo.push_back(cmd[i]);
      wait_idle($sformatf("rnd%0d", r), 5000);
      compare_logs($sformatf("rnd%0d", r));
      check($sformatf("rnd%0d_pops", r), pops, cmd.size());
    end
    rand_gaps = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cm_region_cfg.md
CM_REGION_CFG -- requirements
Module: cm_region_cfg

Interface
REQ-001 SHALL have parameter UART_DATA_WIDTH, default 8, meaning width of one received byte.
REQ-002 SHALL have parameter NUM_REGIONS, default 4, range 1..64, meaning number of configurable screen regions.
REQ-003 SHALL have parameter COLOR_WIDTH, default 12, range 1..32, meaning width of one colour word; NB = ceil(COLOR_WIDTH/8) data bytes per command.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning inter-byte timeout in clk cycles.
REQ-005 SHALL derive localparam c_addr_WIDTH = max(1, clog2(NUM_REGIONS)).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-008 SHALL have port Empty, input, 1: receive FIFO empty; RXD_Data is valid whenever Empty=0 (first-word-fall-through).
REQ-009 SHALL have port RXD_Data, input, UART_DATA_WIDTH: head byte of the receive FIFO.
REQ-010 SHALL have port Rd_En, output, 1: pops the FIFO head on a cycle where it is 1.
REQ-011 SHALL have ports c_addr (output, c_addr_WIDTH), c_data (output, COLOR_WIDTH), c_valid (output, 1) and c_ready (input, 1) forming the colour-write handshake.
REQ-012 SHALL have port Config_Status, output, 2: 00 idle, 01 receiving, 10 issuing, 11 clearing.
REQ-013 SHALL have ports Config_Error (output, 2) and Error_Valid (output, 1).
REQ-014 SHALL have ports Config_Notification (output, c_addr_WIDTH) and Config_Notification_Valid (output, 1).

Function
REQ-015 SHALL decode the header byte as opcode = bits[7:6] and region = bits[5:0]: 00 write colour, 01 clear all regions, 10/11 illegal.
REQ-016 SHALL assert Rd_En only when Empty=0 and the FSM is in IDLE or DATA, for exactly one cycle per byte consumed.
REQ-017 SHALL implement the states IDLE, DATA, ISSUE, CLEAR and ERR.
REQ-018 SHALL, in IDLE, consume the header and then: opcode 00 -> DATA; opcode 01 -> CLEAR; illegal opcode -> ERR with code 10, with no data bytes consumed.
REQ-019 SHALL, in DATA, consume NB bytes MSB-first into a shift register; c_data takes the low COLOR_WIDTH bits and excess high bits are discarded.
REQ-020 SHALL, after the last data byte, go to ISSUE if region < NUM_REGIONS, otherwise go to ERR with code 01 (the data bytes are still consumed so framing is preserved).
REQ-021 SHALL, in ISSUE, assert c_valid with stable c_addr and c_data until the cycle c_valid & c_ready = 1, then return to IDLE; c_valid SHALL rise no earlier than the cycle after the last byte is popped.
REQ-022 SHALL, in CLEAR, issue NUM_REGIONS sequential writes of c_data = 0 to addresses 0..NUM_REGIONS-1, one handshake each, then return to IDLE.
REQ-023 SHALL pulse Config_Notification_Valid for one cycle on each completed handshake, with Config_Notification = the address written.
REQ-024 SHALL, in ERR, pulse Error_Valid for one cycle with Config_Error holding the code, then go to IDLE; Config_Error SHALL hold its last value until the next error.
REQ-025 SHALL keep Rd_En = 0 in ISSUE, CLEAR and ERR, so the FIFO provides the backpressure.
REQ-026 SHALL deassert c_valid in every state other than ISSUE and CLEAR.

Reset
REQ-027 SHALL, when rst=1 on a clock edge, enter IDLE and drive Rd_En, c_valid, Error_Valid and Config_Notification_Valid to 0, c_addr, c_data, Config_Error and Config_Notification to 0, and Config_Status to 00.
REQ-028 SHALL, when reset arrives mid-command or mid-handshake, abandon the command without completing any handshake; partial bytes are lost.

Configuration
REQ-029 SHALL, with macro CM_TIMEOUT_EN defined, count consecutive Empty=1 cycles while in DATA and, on reaching TIMEOUT_CYCLES, go to ERR with code 11 and discard the partial command; the counter SHALL clear on each byte consumed.
REQ-030 SHALL, without CM_TIMEOUT_EN, wait in DATA indefinitely, synthesise no timeout counter, and never produce code 11.

Verification
REQ-031 SHALL verify a basic write (defaults): bytes 8'h02, 8'h05, 8'hA5 -> one handshake with c_addr=2, c_data=12'h5A5, then Config_Notification=2 pulsed.
REQ-032 SHALL verify backpressure: the same write with c_ready=0 for 10 cycles -> c_valid held with stable data, Rd_En=0 while 8'h01 waits in the FIFO, which is consumed after the handshake.
REQ-033 SHALL verify a bad region: bytes 8'h07, 8'h00, 8'h00 -> 3 pops, no c_valid, Error_Valid pulse with Config_Error=01.
REQ-034 SHALL verify an illegal opcode and clear: byte 8'h80 -> Config_Error=10 after one pop; then 8'h40 -> 4 writes, addresses 0..3, data 0.
REQ-035 SHALL verify the timeout (CM_TIMEOUT_EN, TIMEOUT_CYCLES=20): bytes 8'h01, 8'h0F then 20 Empty=1 cycles -> Config_Error=11 and IDLE; without the macro, the third byte after 100 cycles completes the write normally.
REQ-036 SHALL verify reset mid-ISSUE: rst=1 while c_valid=1 and c_ready=0 -> next cycle c_valid=0 and Config_Status=00.
